// File: rtl/mips_pkg.sv
// Shared types and constants for the single-issue MIPS core front end.
package mips_pkg;

    localparam int          OP_WIDTH   = 6;
    localparam int          WORD_WIDTH = 32;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] word;
        logic [WORD_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Prefetch FIFO for the fetch unit: power-of-two depth, flush clears it in one cycle.
module ifu_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t      mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: head is forced to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem reads, 2-entry prefetch queue.
// Optional IFU_FLUSH_CNT_EN adds a saturating redirect counter on flush_count.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [WORD_WIDTH-1:0] instr,
    output logic [WORD_WIDTH-1:0] instr_pc,
    output logic [OP_WIDTH-1:0]   op
`ifdef IFU_FLUSH_CNT_EN
    ,
    output logic [15:0]           flush_count
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t          state, state_nxt;
    logic [WORD_WIDTH-1:0] fetch_pc;
    logic [WORD_WIDTH-1:0] pend_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         post_count;
    logic                  push, pop, issue;
    fetch_entry_t          wentry, head;

    // A redirect voids both the pending write and the decode handshake.
    assign pop        = instr_valid & instr_ready & ~branch_taken;
    assign push       = imem_rvalid & (state == WAIT) & ~branch_taken;
    assign post_count = count + CW'(push) - CW'(pop);
    assign issue      = reset & ~branch_taken
                      & ((state == IDLE) | imem_rvalid)
                      & (post_count < CW'(QDEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT: begin
                if (branch_taken)     state_nxt = imem_rvalid ? IDLE : DISCARD;
                else if (imem_rvalid) state_nxt = issue ? WAIT : IDLE;
            end
            DISCARD: if (imem_rvalid) state_nxt = issue ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= PC_RESET & ~32'h3;
            pend_pc  <= '0;
        end else begin
            state <= state_nxt;
            if (branch_taken) begin
                fetch_pc <= branch_target & ~32'h3;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                pend_pc  <= fetch_pc;
            end
        end
    end

    assign wentry = '{word: imem_rdata, pc: pend_pc};

    ifu_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (branch_taken),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .head  (head),
        .count (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign op          = head.word[31:26];

`ifdef IFU_FLUSH_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     flush_count <= '0;
        else if (branch_taken && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory responder, request/instruction monitor, directed tests.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] PC0 = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  op;
`ifdef IFU_FLUSH_CNT_EN
    logic [15:0] flush_count;
`endif

    int          checks = 0;
    int          failures = 0;
    int          req_cnt = 0;
    int          lat = 1;
    logic [31:0] exp_addr = PC0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .op            (op)
`ifdef IFU_FLUSH_CNT_EN
        ,
        .flush_count   (flush_count)
`endif
    );

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h8C08_0000 | {16'h0, pc[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        branch_taken  = 1'b1;
        branch_target = tgt;
        exp_q.delete();
        exp_addr = tgt & ~32'h3;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_addr + 32'(4 * i));
        step();
        branch_taken = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!instr_valid && n < 30) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting for instr_valid", nm);
        end
    endtask

    // Memory: samples the request just before the edge, answers L edges later.
    initial begin : mem_model
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!reset) pend = 1'b0;
            else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(paddr);
                    pend        = 1'b0;
                end
            end
            @(negedge clk);
            #4;
            if (reset && imem_req) begin
                chk("one_outstanding", 32'(pend), 0);
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
            end
        end
    end

    // Monitor: request addresses and accepted instructions against the scoreboard.
    initial begin : monitor
        logic [31:0] pc_e;
        logic [31:0] w_e;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                if (branch_taken) chk("no_req_on_redirect", 32'(imem_req), 0);
                if (imem_req) begin
                    chk("req_addr", imem_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                    req_cnt++;
                end
                if (instr_valid && instr_ready && !branch_taken) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
                    end else begin
                        pc_e = exp_q.pop_front();
                        w_e  = word_of(pc_e);
                        chk("instr_pc", instr_pc, pc_e);
                        chk("instr", instr, w_e);
                        chk("op", 32'(op), 32'(w_e[31:26]));
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        step(2);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, PC0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_op", 32'(op), 0);
`ifdef IFU_FLUSH_CNT_EN
        chk("rst_flush_count", 32'(flush_count), 0);
`endif

        // L=1, decode always ready
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(PC0 + 32'(4 * i));
        reset = 1'b1;
        step();
        chk("t1_valid_edge1", 32'(instr_valid), 0);
        step();
        chk("t1_valid_edge2", 32'(instr_valid), 1);
        chk("t1_first_pc", instr_pc, PC0);
        chk("t1_first_instr", instr, 32'h8C08_0000);
        chk("t1_first_op", 32'(op), 32'h23);
        step(4);
        instr_ready = 1'b0;
        step(4);
        chk("t1_left_in_queue", 32'(exp_q.size()), 2);
        chk("t1_req_count", 32'(req_cnt), 6);
        reset = 1'b0;
        #1;
        chk("t1_midrst_valid", 32'(instr_valid), 0);
        chk("t1_midrst_req", 32'(imem_req), 0);
        exp_q.delete();
        exp_addr = PC0;
        req_cnt = 0;
        step(2);

        // decode stalled: two words buffered, fetch stops, then drains
        for (int i = 0; i < 16; i++) exp_q.push_back(PC0 + 32'(4 * i));
        reset = 1'b1;
        step(6);
        chk("t2_valid", 32'(instr_valid), 1);
        chk("t2_head_pc", instr_pc, PC0);
        chk("t2_head_instr", instr, 32'h8C08_0000);
        chk("t2_req_count", 32'(req_cnt), 2);
        step(3);
        chk("t2_head_pc_held", instr_pc, PC0);
        chk("t2_req_count_held", 32'(req_cnt), 2);
        instr_ready = 1'b1;
        step();
        chk("t2_resume_req", 32'(req_cnt), 3);
        step(4);
        chk("t2_drained", 32'(exp_q.size()), 11);

        // L=3, redirect while a request is outstanding
        reset = 1'b0;
        exp_q.delete();
        exp_addr = PC0;
        req_cnt = 0;
        lat = 3;
        step(2);
        reset = 1'b1;
        step(2);
        redirect(32'h0040_0103);
        step(3);
        chk("t3_no_stale", 32'(instr_valid), 0);
        chk("t3_req_count", 32'(req_cnt), 2);
        step();
        chk("t3_valid", 32'(instr_valid), 1);
        chk("t3_pc", instr_pc, 32'h0040_0100);

        // redirect coinciding with a response and a handshake
        step();
        instr_ready = 1'b0;
        n = 0;
        while (!(imem_rvalid && instr_valid) && n < 20) begin
            step();
            n++;
        end
        chk("t4_setup", {30'b0, imem_rvalid, instr_valid}, 3);
        instr_ready = 1'b1;
        redirect(32'h0050_0000);
        chk("t4_flushed", 32'(instr_valid), 0);
        wait_valid("t4_wait");
        chk("t4_pc", instr_pc, 32'h0050_0000);
        chk("t4_instr", instr, 32'h8C08_0000);

        // fetch address wraps past the top of memory
        redirect(32'hFFFF_FFFC);
        wait_valid("t5_wait_a");
        chk("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
        step();
        wait_valid("t5_wait_b");
        chk("t5_pc_wrap", instr_pc, 32'h0000_0000);

`ifdef IFU_FLUSH_CNT_EN
        chk("fc_three", 32'(flush_count), 3);
        instr_ready   = 1'b0;
        branch_taken  = 1'b1;
        branch_target = PC0;
        exp_q.delete();
        exp_addr = PC0;
        step(65532);
        chk("fc_reach_max", 32'(flush_count), 32'hFFFF);
        step();
        chk("fc_saturate", 32'(flush_count), 32'hFFFF);
        branch_taken = 1'b0;
`endif

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
